// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad calculator front end: key and op codes,
// state types and the physical key layout.
package keypad_pkg;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
  localparam logic [3:0] KEY_ADD       = 4'd10;
  localparam logic [3:0] KEY_SUB       = 4'd11;
  localparam logic [3:0] KEY_MUL       = 4'd12;
  localparam logic [3:0] KEY_DIV       = 4'd13;
  localparam logic [3:0] KEY_EQ        = 4'd14;
  localparam logic [3:0] KEY_CLR       = 4'd15;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_DIV  = 3'd4;

  typedef enum logic [1:0] {ENTER_A, ENTER_B, DONE} entry_state_e;
  typedef enum logic [1:0] {SCAN, PRESS, RELEASE} scan_state_e;

  // Indexed by {row, col}; rows 0..2 carry 1-9 and + - *, row 3 is C 0 = /.
  localparam logic [15:0][3:0] KEY_MAP = {
    KEY_DIV, KEY_EQ, 4'd0, KEY_CLR,
    KEY_MUL, 4'd9,   4'd8, 4'd7,
    KEY_SUB, 4'd6,   4'd5, 4'd4,
    KEY_ADD, 4'd3,   4'd2, 4'd1
  };

  function automatic logic is_digit(input logic [3:0] k);
    return k <= KEY_DIGIT_MAX;
  endfunction

  function automatic logic [2:0] key_to_op(input logic [3:0] k);
    case (k)
      KEY_ADD: return OP_ADD;
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      KEY_DIV: return OP_DIV;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner with row synchroniser and press/release debounce; emits one
// key_valid pulse per debounced press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic       key_valid_o,
  output logic [3:0] key_code_o
);

  // Rows lag the column by the two synchroniser stages, so a column has to
  // dwell at least three cycles before its rows can be trusted.
  localparam int DWELL = (SCAN_DIV < 3) ? 3 : SCAN_DIV;
  localparam int SW    = $clog2(DWELL);
  localparam int DW    = $clog2(DEBOUNCE + 1);

  logic [3:0]    row_meta_q;
  logic [3:0]    row_sync_q;
  logic [3:0]    col_q;
  logic [SW-1:0] scan_cnt_q;
  logic [DW-1:0] deb_cnt_q;
  logic [3:0]    pattern_q;
  scan_state_e   state_q;
  logic          key_valid_q;
  logic [3:0]    key_code_q;

  logic [3:0] row_low;
  logic       single_low;
  logic [1:0] row_idx;
  logic [1:0] col_idx;

  always_comb begin
    row_low    = ~row_sync_q;
    single_low = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);
    case (pattern_q)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
    case (col_q)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q  <= 4'hF;
      row_sync_q  <= 4'hF;
      col_q       <= 4'b1110;
      scan_cnt_q  <= '0;
      deb_cnt_q   <= '0;
      pattern_q   <= 4'hF;
      state_q     <= SCAN;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
    end else begin
      row_meta_q  <= row_i;
      row_sync_q  <= row_meta_q;
      key_valid_q <= 1'b0;
      case (state_q)
        SCAN: begin
          if (scan_cnt_q >= SW'(2) && row_sync_q != 4'hF) begin
            state_q   <= PRESS;
            pattern_q <= row_sync_q;
            deb_cnt_q <= DW'(1);
          end else if (scan_cnt_q == SW'(DWELL - 1)) begin
            scan_cnt_q <= '0;
            col_q      <= {col_q[2:0], col_q[3]};
          end else begin
            scan_cnt_q <= scan_cnt_q + SW'(1);
          end
        end
        PRESS: begin
          if (row_sync_q == 4'hF) begin
            state_q    <= SCAN;
            scan_cnt_q <= '0;
          end else if (row_sync_q != pattern_q) begin
            pattern_q <= row_sync_q;
            deb_cnt_q <= DW'(1);
          end else if (single_low) begin
            if (int'(deb_cnt_q) + 1 >= DEBOUNCE) begin
              key_valid_q <= 1'b1;
              key_code_q  <= KEY_MAP[{row_idx, col_idx}];
              state_q     <= RELEASE;
              deb_cnt_q   <= '0;
            end else begin
              deb_cnt_q <= deb_cnt_q + DW'(1);
            end
          end
        end
        default: begin
          // Column stays frozen until the rows have been idle long enough.
          if (row_sync_q == 4'hF) begin
            if (int'(deb_cnt_q) + 1 >= DEBOUNCE) begin
              state_q    <= SCAN;
              scan_cnt_q <= '0;
              deb_cnt_q  <= '0;
            end else begin
              deb_cnt_q <= deb_cnt_q + DW'(1);
            end
          end else begin
            deb_cnt_q <= '0;
          end
        end
      endcase
    end
  end

  assign col_o       = col_q;
  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad calculator front end: scans the keypad and assembles two BCD
// operands and an operator from the debounced key stream.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          row,
  output logic [3:0]          col,
  output logic [DIGITS*4-1:0] entry,
  output logic [DIGITS*4-1:0] operand_a,
  output logic [DIGITS*4-1:0] operand_b,
  output logic [2:0]          op,
  output logic                key_valid,
  output logic [3:0]          key_code,
  output logic                result_valid,
  output logic                overflow
);

  localparam int EW = DIGITS * 4;
  localparam int CW = $clog2(DIGITS + 1);

  entry_state_e  state_q;
  logic [EW-1:0] entry_q;
  logic [CW-1:0] count_q;
  logic [EW-1:0] operand_a_q;
  logic [EW-1:0] operand_b_q;
  logic [2:0]    op_q;
  logic          overflow_q;
  logic          result_valid_q;

  keypad_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) u_scanner (
    .clk         (clk),
    .rst_n       (reset),
    .row_i       (row),
    .col_o       (col),
    .key_valid_o (key_valid),
    .key_code_o  (key_code)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ENTER_A;
      entry_q        <= '0;
      count_q        <= '0;
      operand_a_q    <= '0;
      operand_b_q    <= '0;
      op_q           <= OP_NONE;
      overflow_q     <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if (key_valid) begin
        if (key_code == KEY_CLR) begin
          state_q     <= ENTER_A;
          entry_q     <= '0;
          count_q     <= '0;
          operand_a_q <= '0;
          operand_b_q <= '0;
          op_q        <= OP_NONE;
          overflow_q  <= 1'b0;
        end else if (is_digit(key_code)) begin
          if (state_q == DONE) begin
            // A digit after a result starts a fresh calculation.
            operand_a_q <= '0;
            operand_b_q <= '0;
            op_q        <= OP_NONE;
            overflow_q  <= 1'b0;
            entry_q     <= EW'(key_code);
            count_q     <= CW'(1);
            state_q     <= ENTER_A;
          end else if (count_q < CW'(DIGITS)) begin
            entry_q <= (entry_q << 4) | EW'(key_code);
            count_q <= count_q + CW'(1);
          end else begin
            overflow_q <= 1'b1;
          end
        end else if (key_code == KEY_EQ) begin
          if (state_q == ENTER_B && count_q != '0) begin
            operand_b_q    <= entry_q;
            result_valid_q <= 1'b1;
            entry_q        <= '0;
            count_q        <= '0;
            state_q        <= DONE;
          end
        end else begin
          if (state_q == ENTER_A && count_q != '0) begin
            operand_a_q <= entry_q;
            op_q        <= key_to_op(key_code);
            entry_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            state_q     <= ENTER_B;
          end else if (state_q == ENTER_B && count_q == '0) begin
            op_q <= key_to_op(key_code);
          end
        end
      end
    end
  end

  assign entry        = entry_q;
  assign operand_a    = operand_a_q;
  assign operand_b    = operand_b_q;
  assign op           = op_q;
  assign overflow     = overflow_q;
  assign result_valid = result_valid_q;

endmodule
